// File: rtl/pr_axi_pkg.sv
// Shared constants, FSM state and address-channel payload for the PR-region AXI4 burst master.
package pr_axi_pkg;

    localparam int unsigned AXI_ADDR_W = 16;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned BEAT_BYTES = 32;
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int unsigned BEATS_4K   = 4096 / BEAT_BYTES;
    localparam int unsigned PAGE_OFF_W = $clog2(BEATS_4K);

    localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE      = 4'b0011;
    localparam logic [2:0] AXI_PROT       = 3'b000;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDAT,
        ST_BRSP,
        ST_RDAT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [LEN_W-1:0]      len;
    } ax_t;

endpackage

// File: rtl/pr_axi_seg_calc.sv
// Burst segmentation: length of the next 4 KB-bounded segment, and the address/remaining
// count after the segment currently in flight completes.
module pr_axi_seg_calc
    import pr_axi_pkg::*;
#(
    parameter int unsigned BEATS_W = 9
) (
    input  logic [PAGE_OFF_W-1:0] beat_off_i,
    input  logic [BEATS_W-1:0]    rem_i,
    output logic [LEN_W-1:0]      len_o,
    input  logic [AXI_ADDR_W-1:0] cur_addr_i,
    input  logic [BEATS_W-1:0]    cur_rem_i,
    input  logic [LEN_W-1:0]      cur_len_i,
    output logic [AXI_ADDR_W-1:0] next_addr_o,
    output logic [BEATS_W-1:0]    next_rem_o
);

    logic [BEATS_W-1:0] room;
    logic [BEATS_W-1:0] seg;
    logic [BEATS_W-1:0] cur_seg;

    always_comb begin
        room        = BEATS_W'(BEATS_4K) - BEATS_W'(beat_off_i);
        seg         = (rem_i < room) ? rem_i : room;
        len_o       = LEN_W'(seg - BEATS_W'(1));
        cur_seg     = BEATS_W'(cur_len_i) + BEATS_W'(1);
        // address arithmetic wraps modulo the 16-bit window
        next_addr_o = cur_addr_i + (AXI_ADDR_W'(cur_seg) << BEAT_SHIFT);
        next_rem_o  = cur_rem_i - cur_seg;
    end

endmodule

// File: rtl/pr_axi_burst_master.sv
// Command-to-AXI4 burst engine for the PR region: splits one command into INCR bursts,
// streams write/read data and reports a single completion status.
module pr_axi_burst_master
    import pr_axi_pkg::*;
#(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_BEATS = 256
) (
    input  logic                      s_axi_aclk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [$clog2(MAX_BEATS):0] cmd_beats,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      rd_last,
    output logic                      done_valid,
    output logic                      done_err,
    output logic [ADDR_W-1:0]         m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [DATA_W-1:0]         m_axi_wdata,
    output logic [DATA_W/8-1:0]       m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    input  logic [DATA_W-1:0]         m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int unsigned BEATS_W = $clog2(MAX_BEATS) + 1;

    state_e                state_q, state_d;
    ax_t                   ax_q, ax_d;
    logic [AXI_ADDR_W-1:0] addr_d;
    logic [BEATS_W-1:0]    rem_q, rem_d;
    logic [LEN_W-1:0]      beat_q, beat_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic                  cmd_ready_q, cmd_ready_d;

    logic [LEN_W-1:0]      len_nxt;
    logic [AXI_ADDR_W-1:0] next_addr;
    logic [BEATS_W-1:0]    next_rem;
    logic                  beat_last;
    logic                  rlast_unused;

    // Beat counting governs burst boundaries; the slave's rlast is ignored.
    assign rlast_unused = m_axi_rlast;

    // Length follows the address/remaining values being loaded, so aw/ar fields are registered.
    pr_axi_seg_calc #(
        .BEATS_W (BEATS_W)
    ) u_seg_calc (
        .beat_off_i  (addr_d[11:BEAT_SHIFT]),
        .rem_i       (rem_d),
        .len_o       (len_nxt),
        .cur_addr_i  (ax_q.addr),
        .cur_rem_i   (rem_q),
        .cur_len_i   (ax_q.len),
        .next_addr_o (next_addr),
        .next_rem_o  (next_rem)
    );

    assign beat_last = (beat_q == ax_q.len);

    always_comb begin
        state_d = state_q;
        addr_d  = ax_q.addr;
        rem_d   = rem_q;
        beat_d  = beat_q;
        write_d = write_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr & ~AXI_ADDR_W'(BEAT_BYTES - 1);
                    rem_d   = cmd_beats;
                    write_d = cmd_write;
                    beat_d  = '0;
                    err_d   = (cmd_beats == '0);
                    state_d = (cmd_beats == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                beat_d = '0;
                if (write_q && m_axi_awready) begin
                    state_d = ST_WDAT;
                end else if (!write_q && m_axi_arready) begin
                    state_d = ST_RDAT;
                end
            end
            ST_WDAT: begin
                if (wr_valid && m_axi_wready) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (beat_last) begin
                        state_d = ST_BRSP;
                    end
                end
            end
            ST_BRSP: begin
                if (m_axi_bvalid) begin
                    err_d   = err_q | (m_axi_bresp != AXI_RESP_OKAY);
                    addr_d  = next_addr;
                    rem_d   = next_rem;
                    beat_d  = '0;
                    state_d = (next_rem == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_RDAT: begin
                if (m_axi_rvalid && rd_ready) begin
                    err_d  = err_q | (m_axi_rresp != AXI_RESP_OKAY);
                    beat_d = beat_q + LEN_W'(1);
                    if (beat_last) begin
                        addr_d  = next_addr;
                        rem_d   = next_rem;
                        beat_d  = '0;
                        state_d = (next_rem == '0) ? ST_DONE : ST_ADDR;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        ax_d        = '{addr: addr_d, len: len_nxt};
    end

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ax_q        <= '0;
            rem_q       <= '0;
            beat_q      <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ax_q        <= ax_d;
            rem_q       <= rem_d;
            beat_q      <= beat_d;
            write_q     <= write_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign done_valid    = (state_q == ST_DONE);
    assign done_err      = (state_q == ST_DONE) && err_q;

    assign m_axi_awaddr  = ax_q.addr;
    assign m_axi_awlen   = ax_q.len;
    assign m_axi_awsize  = AXI_SIZE_32B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE;
    assign m_axi_awprot  = AXI_PROT;
    assign m_axi_awvalid = (state_q == ST_ADDR) && write_q;

    assign m_axi_araddr  = ax_q.addr;
    assign m_axi_arlen   = ax_q.len;
    assign m_axi_arsize  = AXI_SIZE_32B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_CACHE;
    assign m_axi_arprot  = AXI_PROT;
    assign m_axi_arvalid = (state_q == ST_ADDR) && !write_q;

    // Data streams pass straight through while the matching data state is active.
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = (state_q == ST_WDAT) && wr_valid;
    assign m_axi_wlast   = (state_q == ST_WDAT) && beat_last;
    assign wr_ready      = (state_q == ST_WDAT) && m_axi_wready;
    assign m_axi_bready  = (state_q == ST_BRSP);

    assign rd_data       = m_axi_rdata;
    assign rd_valid      = (state_q == ST_RDAT) && m_axi_rvalid;
    assign rd_last       = rd_valid && beat_last && (next_rem == '0);
    assign m_axi_rready  = (state_q == ST_RDAT) && rd_ready;

endmodule

// File: tb/tb_pr_axi_burst_master.sv
// Directed bench for pr_axi_burst_master: vector table of commands against an always-ready
// AXI slave model, plus reset and mid-burst reset sequences.
module tb_pr_axi_burst_master;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid, cmd_ready, cmd_write;
    logic [15:0]  cmd_addr;
    logic [8:0]   cmd_beats;
    logic [255:0] wr_data;
    logic         wr_valid, wr_ready;
    logic [255:0] rd_data;
    logic         rd_valid, rd_ready, rd_last;
    logic         done_valid, done_err;
    logic [15:0]  m_axi_awaddr, m_axi_araddr;
    logic [7:0]   m_axi_awlen, m_axi_arlen;
    logic [2:0]   m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]   m_axi_awburst, m_axi_arburst;
    logic         m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic         m_axi_awlock, m_axi_arlock;
    logic [3:0]   m_axi_awcache, m_axi_arcache;
    logic [255:0] m_axi_wdata, m_axi_rdata;
    logic [31:0]  m_axi_wstrb;
    logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]   m_axi_bresp, m_axi_rresp;
    logic         m_axi_bvalid, m_axi_bready;
    logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    pr_axi_burst_master dut (
        .s_axi_aclk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .done_valid(done_valid), .done_err(done_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // Slave model: always ready on AW/W/AR, B one cycle after wlast, R counter data.
    logic [1:0]  slave_resp;
    logic [8:0]  r_left;
    logic [31:0] rd_ctr, wr_seq;
    logic        tgl, tgl_mode;

    assign m_axi_awready = 1'b1;
    assign m_axi_wready  = 1'b1;
    assign m_axi_arready = 1'b1;
    assign m_axi_bresp   = slave_resp;
    assign m_axi_rresp   = slave_resp;
    assign m_axi_rdata   = 256'(rd_ctr);
    assign m_axi_rlast   = (r_left == 9'd1);
    assign wr_data       = 256'(wr_seq);
    assign rd_ready      = tgl_mode ? tgl : 1'b1;

    always @(posedge clk) begin
        if (reset) begin
            m_axi_bvalid <= 1'b0;
            m_axi_rvalid <= 1'b0;
            r_left       <= '0;
            rd_ctr       <= '0;
            wr_seq       <= '0;
            tgl          <= 1'b0;
        end else begin
            tgl <= ~tgl;
            if (wr_valid && wr_ready) wr_seq <= wr_seq + 1;
            if (m_axi_wvalid && m_axi_wready && m_axi_wlast) m_axi_bvalid <= 1'b1;
            else if (m_axi_bvalid && m_axi_bready)           m_axi_bvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                r_left       <= 9'(m_axi_arlen) + 9'd1;
                m_axi_rvalid <= 1'b1;
            end else if (m_axi_rvalid && m_axi_rready) begin
                rd_ctr <= rd_ctr + 1;
                r_left <= r_left - 9'd1;
                if (r_left == 9'd1) m_axi_rvalid <= 1'b0;
            end
        end
    end

    // Monitor on the falling edge: burst log, beat counts, stream ordering and wlast placement.
    int          cyc, w_cnt, rd_cnt, last_cnt, last_at, mon_err, hs_cyc, w_in_burst;
    logic [7:0]  cur_len;
    logic [31:0] w_exp, r_exp;
    bit          aw_out;
    logic [15:0] ax_addr_log[$];
    logic [7:0]  ax_len_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            w_in_burst <= 0;
            aw_out     <= 1'b0;
            w_exp      <= '0;
            r_exp      <= '0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                ax_addr_log.push_back(m_axi_awaddr);
                ax_len_log.push_back(m_axi_awlen);
                cur_len <= m_axi_awlen;
                aw_out  <= 1'b1;
                if (aw_out) mon_err <= mon_err + 1;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ax_addr_log.push_back(m_axi_araddr);
                ax_len_log.push_back(m_axi_arlen);
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_cnt <= w_cnt + 1;
                if (!aw_out || m_axi_wdata !== 256'(w_exp) ||
                    m_axi_wlast !== (w_in_burst == int'(cur_len)))
                    mon_err <= mon_err + 1;
                w_exp      <= w_exp + 1;
                w_in_burst <= (w_in_burst == int'(cur_len)) ? 0 : w_in_burst + 1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                aw_out <= 1'b0;
                hs_cyc <= cyc;
            end
            if (rd_valid && rd_ready) begin
                rd_cnt <= rd_cnt + 1;
                if (rd_data !== 256'(r_exp)) mon_err <= mon_err + 1;
                r_exp  <= r_exp + 1;
                hs_cyc <= cyc;
                if (rd_last) begin
                    last_cnt <= last_cnt + 1;
                    last_at  <= rd_cnt + 1;
                end
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [8:0]  beats;
        logic [1:0]  resp;
        bit          tgl;
        int          nb;
        logic [15:0] ea[3];
        logic [7:0]  el[3];
        bit          eerr;
    } vec_t;

    vec_t vecs[8];

    task automatic issue(input bit wr, input logic [15:0] addr, input logic [8:0] beats);
        bit got = 1'b0;
        @(posedge clk) #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_beats = beats;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("cmd_accept", 32'(got), 32'd1);
        @(posedge clk) #1;
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int w0, r0, lc0, me0, lg0, n;
        bit got;
        w0 = w_cnt; r0 = rd_cnt; lc0 = last_cnt; me0 = mon_err; lg0 = ax_addr_log.size();
        slave_resp = v.resp;
        tgl_mode   = v.tgl;
        issue(v.wr, v.addr, v.beats);
        chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
        if (v.beats != 9'd0)
            chk("addr_valid_lat", 32'(v.wr ? m_axi_awvalid : m_axi_arvalid), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("done_err", 32'(done_err), 32'(v.eerr));
        if (v.beats != 9'd0) chk("done_latency", 32'(cyc - hs_cyc), 32'd1);
        @(negedge clk);
        n = ax_addr_log.size() - lg0;
        chk("burst_count", 32'(n), 32'(v.nb));
        for (int b = 0; b < v.nb && b < n; b++) begin
            chk("burst_addr", 32'(ax_addr_log[lg0 + b]), 32'(v.ea[b]));
            chk("burst_len", 32'(ax_len_log[lg0 + b]), 32'(v.el[b]));
        end
        chk("beats_moved", 32'(v.wr ? (w_cnt - w0) : (rd_cnt - r0)), 32'(v.beats));
        chk("rd_last_count", 32'(last_cnt - lc0), (!v.wr && v.beats != 9'd0) ? 32'd1 : 32'd0);
        if (!v.wr && v.beats != 9'd0) chk("rd_last_pos", 32'(last_at - r0), 32'(v.beats));
        chk("stream_order", 32'(mon_err - me0), 32'd0);
        tgl_mode = 1'b0;
    endtask

    initial begin
        int  wsnap;
        bit  got;

        vecs[0] = '{1'b1, 16'h0100, 9'd4,   2'b00, 1'b0, 1, '{16'h0100, 16'h0000, 16'h0000}, '{8'd3,   8'd0,   8'd0},   1'b0};
        vecs[1] = '{1'b1, 16'h0F00, 9'd256, 2'b00, 1'b0, 3, '{16'h0F00, 16'h1000, 16'h2000}, '{8'd7,   8'd127, 8'd119}, 1'b0};
        vecs[2] = '{1'b0, 16'h4000, 9'd16,  2'b00, 1'b1, 1, '{16'h4000, 16'h0000, 16'h0000}, '{8'd15,  8'd0,   8'd0},   1'b0};
        vecs[3] = '{1'b0, 16'hFFE0, 9'd2,   2'b00, 1'b0, 2, '{16'hFFE0, 16'h0000, 16'h0000}, '{8'd0,   8'd0,   8'd0},   1'b0};
        vecs[4] = '{1'b1, 16'h0200, 9'd8,   2'b10, 1'b0, 1, '{16'h0200, 16'h0000, 16'h0000}, '{8'd7,   8'd0,   8'd0},   1'b1};
        vecs[5] = '{1'b1, 16'h0300, 9'd0,   2'b00, 1'b0, 0, '{16'h0000, 16'h0000, 16'h0000}, '{8'd0,   8'd0,   8'd0},   1'b1};
        vecs[6] = '{1'b0, 16'h301F, 9'd5,   2'b00, 1'b0, 1, '{16'h3000, 16'h0000, 16'h0000}, '{8'd4,   8'd0,   8'd0},   1'b0};
        vecs[7] = '{1'b0, 16'h0FC0, 9'd3,   2'b10, 1'b0, 2, '{16'h0FC0, 16'h1000, 16'h0000}, '{8'd1,   8'd0,   8'd0},   1'b1};

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_beats = '0;
        wr_valid = 1'b1; tgl_mode = 1'b0; slave_resp = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_done_err", 32'(done_err), 32'd0);
        chk("rst_valids", 32'({m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, m_axi_rready, rd_valid, wr_ready}), 32'd0);
        chk("const_size", 32'({m_axi_awsize, m_axi_arsize}), 32'h2D);
        chk("const_burst", 32'({m_axi_awburst, m_axi_arburst}), 32'h5);
        chk("const_cache", 32'({m_axi_awcache, m_axi_arcache}), 32'h33);
        chk("const_lock_prot", 32'({m_axi_awlock, m_axi_arlock, m_axi_awprot, m_axi_arprot}), 32'd0);
        chk("const_wstrb", m_axi_wstrb, 32'hFFFF_FFFF);
        @(posedge clk) #1 reset = 1'b0;
        @(negedge clk);
        chk("cmd_ready_at_release", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("cmd_ready_after_release", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of a 10-beat write.
        wsnap = w_cnt;
        issue(1'b1, 16'h0000, 9'd10);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (w_cnt - wsnap >= 4) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_beats_reached", 32'(got), 32'd1);
        @(posedge clk) #1 reset = 1'b1;
        @(posedge clk) #1;
        @(negedge clk);
        chk("midrst_valids", 32'({m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, rd_valid, wr_ready}), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("midrst_done", 32'(done_valid), 32'd0);
        wsnap = w_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_cmd_ready_release", 32'(cmd_ready), 32'd1);
        chk("midrst_no_more_beats", 32'(w_cnt), 32'(wsnap));
        run_vec(vecs[0]);
        run_vec(vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pr_axi_burst_master.md
# pr_axi_burst_master

Upstream command-to-AXI4 burst engine that drives the 256-bit AXI4 slave port of the partial-reconfiguration region (16-bit address window, DDR4-backed). It accepts one transfer command at a time, splits it into legal INCR bursts, streams write data in or read data out, and reports a single completion status. It sits between the PCIe-side control logic and the PR region in the static partition.

## Interface
Parameters:
- DATA_W, 256, AXI data width; fixed, not intended for override.
- ADDR_W, 16, AXI address width.
- MAX_BEATS, 256, largest command length in beats.

Ports:
- s_axi_aclk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  16  start byte address; bits [4:0] ignored (32-byte aligned).
- cmd_beats  in  9  beat count, 1..256; 0 is illegal.
- wr_data / wr_valid / wr_ready  in / in / out  256 / 1 / 1  write data stream.
- rd_data / rd_valid / rd_ready / rd_last  out / out / in / out  256 / 1 / 1 / 1  read data stream.
- done_valid  out  1  one-cycle completion pulse.
- done_err  out  1  valid with done_valid; 1 = any non-OKAY response or illegal command.
- m_axi_aw{addr,len,size,burst,valid}  out  16/8/3/2/1; m_axi_awready  in  1.
- m_axi_w{data,strb,last,valid}  out  256/32/1/1; m_axi_wready  in  1.
- m_axi_b{resp,valid}  in  2/1; m_axi_bready  out  1.
- m_axi_ar{addr,len,size,burst,valid}  out  16/8/3/2/1; m_axi_arready  in  1.
- m_axi_r{data,resp,last,valid}  in  256/2/1/1; m_axi_rready  out  1.
- m_axi_{aw,ar}lock/cache/prot  out  1/4/3  constants 0 / 4'b0011 / 3'b000.

## Operation
- Constants: awsize = arsize = 3'b101, burst = 2'b01 (INCR), wstrb = all ones.
- FSM: IDLE, ADDR, WDAT, BRSP, RDAT, DONE.
- IDLE: cmd_ready = 1. On accept, latch addr (bits [4:0] forced 0), remaining = cmd_beats, clear err. cmd_beats = 0 -> DONE with err = 1, no AXI traffic.
- ADDR: segment = min(remaining, 128 - addr[11:5]) (no burst crosses a 4 KB boundary). Assert awvalid (write) or arvalid (read) with len = segment - 1; hold until ready, then WDAT or RDAT.
- WDAT: wvalid = wr_valid, wr_ready = wready, wdata = wr_data, zero bubbles; wlast on final beat of segment; then BRSP.
- BRSP: bready = 1; on bvalid, err |= (bresp != 0).
- RDAT: rd_valid = rvalid, rready = rd_ready, rd_data = rdata; err |= (rresp != 0) per beat; rd_last on last beat of the whole command only.
- After a segment: addr += segment*32 (mod 2^16, wraps); remaining -= segment; remaining > 0 -> ADDR, else DONE.
- DONE: done_valid = 1 for one cycle with done_err = err; next IDLE.
- Slave rlast is not checked; beat counting governs.

## Timing
- Reset: all valid/ready outputs 0, cmd_ready 0, done_valid 0, done_err 0, state IDLE; cmd_ready rises the cycle after reset deasserts.
- Reset mid-operation aborts immediately; no further AXI beats; in-flight slave responses are the slave's concern.
- Command accept to awvalid/arvalid: 1 cycle. Last B/R beat to done_valid: 1 cycle.
- AW/AR and W/R stream signals are combinational pass-through gated by state; aw/ar fields are registered.
- Only one burst outstanding; W never precedes AW handshake.
- cmd_ready = 0 from accept through DONE.

## Structure
- Shared package pr_axi_pkg: AXI size/burst/cache constants, beat-bytes (32), 4 KB beat count (128), FSM state enum.
- One sub-module natural: pr_axi_seg_calc (combinational segment length and next-address computation).

## Test plan
- Write 4 beats at 0x0100, slave always ready -> one AW len 3 addr 0x0100, 4 W beats, wlast on 4th, done_err 0.
- Write 256 beats at 0x0F00 -> AW bursts (0x0F00 len 7), (0x1000 len 127), (0x2000 len 119); done after 3rd B.
- Read 16 beats at 0x4000 with rd_ready toggling every cycle -> no dropped/duplicated beats, rd_last on 16th only.
- Read 2 beats at 0xFFE0 -> AR (0xFFE0 len 0), AR (0x0000 len 0); done_err 0.
- Write 8 beats, slave bresp = SLVERR -> done_valid with done_err 1; cmd_beats = 0 -> done_err 1, no AW.
- Assert reset during 5th of 10 W beats -> all valids 0 next cycle, cmd_ready 1 after release, new command runs cleanly.
